// File: rtl/dc_motor_ctrl.sv
// dc_motor_ctrl: multi-channel DC motor direction + PWM speed controller with dead time.
// Latency: a request before edge N moves the FSM at edge N; out_a/out_b/busy follow at N+1, led at N.
// Backpressure: none; requests are levels, and a channel in DEAD ignores them until dead time expires.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   en              global enable; 0 acts as a stop request on every channel
//   cmd_fwd/cmd_rev per-channel level requests (both set = stop)
//   duty            packed per-channel duty, channel i at [i*PWM_W +: PWM_W]
//   out_a/out_b     registered H-bridge forward/reverse legs
//   busy            channel is in its dead-time window
//   led             channel-0 status: 101 fwd, 110 rev, 000 conflict, 011 otherwise
// Build option: define DC_MOTOR_BRAKE_EN to drive both legs high in STOP (brake) instead of coasting.
module dc_motor_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int PWM_W    = 8,
  parameter int DEAD_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       cmd_fwd,
  input  logic [NUM_CH-1:0]       cmd_rev,
  input  logic [NUM_CH*PWM_W-1:0] duty,
  output logic [NUM_CH-1:0]       out_a,
  output logic [NUM_CH-1:0]       out_b,
  output logic [NUM_CH-1:0]       busy,
  output logic [2:0]              led
);

  localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'(DEAD_CYC - 1);

  typedef enum logic [1:0] {ST_STOP, ST_FWD, ST_REV, ST_DEAD} state_e;

  state_e            state_q    [NUM_CH];
  state_e            state_d    [NUM_CH];
  logic [DC_W-1:0]   dead_cnt_q [NUM_CH];
  logic [DC_W-1:0]   dead_cnt_d [NUM_CH];
  logic [PWM_W-1:0]  duty_q     [NUM_CH];
  logic [PWM_W-1:0]  duty_d     [NUM_CH];
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0] out_a_q, out_a_d;
  logic [NUM_CH-1:0] out_b_q, out_b_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [2:0]        led_q, led_d;

  logic [NUM_CH-1:0] req_fwd, req_rev, pwm_on, stop_drive;
  logic              period_end;

  // A conflicting fwd+rev request decodes as neither, i.e. stop.
  always_comb begin
    req_fwd = en ? (cmd_fwd & ~cmd_rev) : '0;
    req_rev = en ? (cmd_rev & ~cmd_fwd) : '0;
  end

  always_comb begin
    period_end = &pwm_cnt_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]    = state_q[i];
      dead_cnt_d[i] = dead_cnt_q[i];
      // Duty is only sampled on the last count so a period is never cut short or stretched.
      duty_d[i]     = period_end ? duty[i*PWM_W +: PWM_W] : duty_q[i];

      case (state_q[i])
        ST_STOP: begin
          if (req_fwd[i])      state_d[i] = ST_FWD;
          else if (req_rev[i]) state_d[i] = ST_REV;
        end
        ST_FWD: begin
          if (!req_fwd[i]) begin
            state_d[i]    = ST_DEAD;
            dead_cnt_d[i] = DEAD_LOAD;
          end
        end
        ST_REV: begin
          if (!req_rev[i]) begin
            state_d[i]    = ST_DEAD;
            dead_cnt_d[i] = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          // Requests are ignored until the window expires, even a return to the old direction.
          if (dead_cnt_q[i] != '0)  dead_cnt_d[i] = dead_cnt_q[i] - 1'b1;
          else if (req_fwd[i])      state_d[i]    = ST_FWD;
          else if (req_rev[i])      state_d[i]    = ST_REV;
          else                      state_d[i]    = ST_STOP;
        end
        default: state_d[i] = ST_STOP;
      endcase

      pwm_on[i] = (pwm_cnt_q < duty_q[i]);
`ifdef DC_MOTOR_BRAKE_EN
      stop_drive[i] = (state_q[i] == ST_STOP);
`else
      stop_drive[i] = 1'b0;
`endif
      out_a_d[i] = ((state_q[i] == ST_FWD) & pwm_on[i]) | stop_drive[i];
      out_b_d[i] = ((state_q[i] == ST_REV) & pwm_on[i]) | stop_drive[i];
      busy_d[i]  = (state_q[i] == ST_DEAD);
    end
  end

  always_comb begin
    led_d = 3'b011;
    if (req_fwd[0])                         led_d = 3'b101;
    else if (req_rev[0])                    led_d = 3'b110;
    else if (en & cmd_fwd[0] & cmd_rev[0])  led_d = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      busy_q    <= '0;
      led_q     <= 3'b011;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= ST_STOP;
        dead_cnt_q[i] <= '0;
        duty_q[i]     <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= state_d[i];
        dead_cnt_q[i] <= dead_cnt_d[i];
        duty_q[i]     <= duty_d[i];
      end
    end
  end

  assign out_a = out_a_q;
  assign out_b = out_b_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_dc_motor_ctrl.sv
`timescale 1ns/1ps
module tb_dc_motor_ctrl;
  localparam int NUM_CH   = 2;
  localparam int PWM_W    = 4;
  localparam int DEAD_CYC = 4;
`ifdef DC_MOTOR_BRAKE_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  cmd_fwd, cmd_rev;
  logic [7:0]  duty;
  logic [1:0]  out_a, out_b, busy;
  logic [2:0]  led;

  dc_motor_ctrl #(.NUM_CH(NUM_CH), .PWM_W(PWM_W), .DEAD_CYC(DEAD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmd_fwd(cmd_fwd), .cmd_rev(cmd_rev),
    .duty(duty), .out_a(out_a), .out_b(out_b), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  // Output vector layout: {out_a[1:0], out_b[1:0], busy[1:0], led[2:0]}
  typedef struct {
    int         cyc;
    logic [8:0] mask;
    logic [8:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int ntests = 0;
  int nfail  = 0;
  int scyc   = 0;
  int mcyc   = 0;
  int p      = 0;   // expected pwm count after the latest edge

  always @(posedge clk) mcyc <= mcyc + 1;

  // Monitor: every cycle, compare all expectations queued for this cycle.
  initial begin
    exp_t       e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      got = {out_a, out_b, busy, led};
      while (sb.size() > 0 && sb[0].cyc <= mcyc) begin
        e = sb.pop_front();
        ntests++;
        if (e.cyc != mcyc) begin
          nfail++;
          $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, mcyc);
        end else if ((got & e.mask) !== (e.val & e.mask)) begin
          nfail++;
          $display("FAIL %s @cyc %0d: got %b required %b (mask %b)",
                   e.name, mcyc, got & e.mask, e.val & e.mask, e.mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    p = (rst_n === 1'b0) ? 0 : (p + 1) % 16;
    scyc++;
    #1;
  endtask

  task automatic chk_ch(input int ch, input bit a, input bit b, input bit bz, input string nm);
    exp_t e;
    e.cyc  = scyc;
    e.mask = '0;
    e.val  = '0;
    e.mask[7+ch] = 1'b1; e.val[7+ch] = a;
    e.mask[5+ch] = 1'b1; e.val[5+ch] = b;
    e.mask[3+ch] = 1'b1; e.val[3+ch] = bz;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic chk_led(input logic [2:0] l, input string nm);
    exp_t e;
    e.cyc  = scyc;
    e.mask = 9'b000_000_111;
    e.val  = {6'b0, l};
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic chk_all(input logic [1:0] a, input logic [1:0] b, input logic [1:0] bz,
                         input logic [2:0] l, input string nm);
    exp_t e;
    e.cyc  = scyc;
    e.mask = '1;
    e.val  = {a, b, bz, l};
    e.name = nm;
    sb.push_back(e);
  endtask

  // Runs two periods on channel 0 (FWD) starting at p==0; the first uses old_d, the second new_d.
  // chg_p < 0 drives the new duty immediately, otherwise when the count reaches chg_p.
  task automatic run_duty(input int old_d, input int new_d, input int chg_p, input string nm);
    if (chg_p < 0) duty[3:0] = 4'(new_d);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk_ch(0, (i % 16) < ((i < 16) ? old_d : new_d), 1'b0, 1'b0, nm);
      if (i < 16 && p == chg_p) duty[3:0] = 4'(new_d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'($urandom_range(0, 1));
    cmd_fwd = 2'($urandom_range(0, 3));
    cmd_rev = 2'($urandom_range(0, 3));
    duty    = 8'($urandom_range(0, 255));

    // Reset with random inputs
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all(2'b00, 2'b00, 2'b00, 3'b011, "reset");
      en      = 1'($urandom_range(0, 1));
      cmd_fwd = 2'($urandom_range(0, 3));
      cmd_rev = 2'($urandom_range(0, 3));
      duty    = 8'($urandom_range(0, 255));
    end
    rst_n = 1'b1; en = 1'b1; cmd_fwd = 2'b00; cmd_rev = 2'b00; duty = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all({BRK, BRK}, {BRK, BRK}, 2'b00, 3'b011, "idle_after_reset");
    end

    // ch0 forward at duty 8 (p==4 now)
    cmd_fwd[0] = 1'b1; duty[3:0] = 4'd8;
    tick();
    chk_ch(0, BRK, BRK, 1'b0, "fwd_start");
    chk_led(3'b101, "led_fwd");
    for (int k = 0; k < 11; k++) begin
      tick();
      chk_ch(0, 1'b0, 1'b0, 1'b0, "fwd_before_wrap");
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      chk_ch(0, ((p + 15) % 16) < 8, 1'b0, 1'b0, "fwd_pwm8");
      chk_ch(1, BRK, BRK, 1'b0, "ch1_idle");
      chk_led(3'b101, "led_fwd_run");
    end

    // Reverse ch0 (p==0)
    cmd_fwd[0] = 1'b0; cmd_rev[0] = 1'b1;
    tick();
    chk_ch(0, 1'b1, 1'b0, 1'b0, "rev_last_fwd");
    chk_led(3'b110, "led_rev");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ch(0, 1'b0, 1'b0, 1'b1, "reversal_dead");
    end
    for (int k = 0; k < 27; k++) begin
      tick();
      chk_ch(0, 1'b0, ((p + 15) % 16) < 8, 1'b0, "rev_pwm8");
    end

    // ch1 reverse at duty 12, then conflict -> dead -> stop (p==0)
    cmd_rev[1] = 1'b1; duty[7:4] = 4'd12;
    tick();
    chk_ch(1, BRK, BRK, 1'b0, "ch1_rev_start");
    for (int k = 0; k < 15; k++) begin
      tick();
      chk_ch(1, 1'b0, 1'b0, 1'b0, "ch1_rev_zero_duty");
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ch(1, 1'b0, 1'b1, 1'b0, "ch1_rev_pwm12");
    end
    cmd_fwd[1] = 1'b1;
    tick();
    chk_ch(1, 1'b0, 1'b1, 1'b0, "ch1_conflict_edge");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ch(1, 1'b0, 1'b0, 1'b1, "ch1_conflict_dead");
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ch(1, BRK, BRK, 1'b0, "ch1_conflict_stop");
    end
    cmd_fwd[1] = 1'b0; cmd_rev[1] = 1'b0;

    // ch0 conflict: led 000, REV -> DEAD -> STOP (p==12)
    cmd_fwd[0] = 1'b1;
    tick();
    chk_led(3'b000, "led_conflict");
    chk_ch(0, 1'b0, 1'b0, 1'b0, "ch0_conflict_edge");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ch(0, 1'b0, 1'b0, 1'b1, "ch0_conflict_dead");
      chk_led(3'b000, "led_conflict_hold");
    end
    tick();
    chk_ch(0, BRK, BRK, 1'b0, "ch0_conflict_stop");

    // Global disable masks the forward request (p==2)
    en = 1'b0; cmd_rev[0] = 1'b0;
    tick();
    chk_led(3'b011, "led_en_off");
    chk_ch(0, BRK, BRK, 1'b0, "en_off_stop");

    // Re-enable forward, then duty update scenarios (p==3)
    en = 1'b1;
    tick();
    chk_led(3'b101, "led_fwd_again");
    chk_ch(0, BRK, BRK, 1'b0, "fwd_again_start");
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_ch(0, ((p + 15) % 16) < 8, 1'b0, 1'b0, "fwd_resume");
    end
    run_duty(8, 3, 5, "duty_8_to_3_mid");
    run_duty(3, 0, -1, "duty_3_to_0");
    run_duty(0, 15, -1, "duty_0_to_15");

    // Reset while dead_cnt == 2 (p==0)
    cmd_fwd[0] = 1'b0;
    tick();
    chk_ch(0, 1'b1, 1'b0, 1'b0, "pre_dead_fwd");
    tick();
    chk_ch(0, 1'b0, 1'b0, 1'b1, "dead_before_rst");
    rst_n = 1'b0;
    tick();
    chk_all(2'b00, 2'b00, 2'b00, 3'b011, "rst_mid_dead");
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_ch(0, BRK, BRK, 1'b0, "stop_after_rst");
    end

    // FWD -> STOP: dead window, then coast or brake (p==2)
    cmd_fwd[0] = 1'b1;
    tick();
    chk_ch(0, BRK, BRK, 1'b0, "stopseq_fwd_start");
    for (int k = 0; k < 13; k++) begin
      tick();
      chk_ch(0, 1'b0, 1'b0, 1'b0, "stopseq_zero_duty");
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ch(0, 1'b1, 1'b0, 1'b0, "stopseq_fwd15");
    end
    cmd_fwd[0] = 1'b0;
    tick();
    chk_ch(0, 1'b1, 1'b0, 1'b0, "stopseq_last_fwd");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ch(0, 1'b0, 1'b0, 1'b1, "stopseq_dead");
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ch(0, BRK, BRK, 1'b0, "stopseq_stop_drive");
    end

    tick();
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dc_motor_ctrl.md
Name: dc_motor_ctrl

Overview:
- Parametrised multi-channel DC motor direction and speed controller. It is the successor to the single-motor, two-input direction blocks.
- Each channel runs an FSM (STOP/FWD/REV/DEAD) that enforces dead time on every drive change, plus PWM speed control from a shared period counter.
- It also drives the 3-bit status LED from channel 0.
- It sits between the user command inputs and the H-bridge gate pins.

Parameters:
NUM_CH, 2, number of motor channels (>=1)
PWM_W, 8, PWM counter and duty width; PWM period = 2^PWM_W clk cycles
DEAD_CYC, 16, cycles in DEAD with both bridge outputs low (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
en  input  1  global enable; 0 = stop request on all channels
cmd_fwd  input  NUM_CH  per-channel forward request (level)
cmd_rev  input  NUM_CH  per-channel reverse request (level)
duty  input  NUM_CH*PWM_W  per-channel duty; channel i uses bits [i*PWM_W +: PWM_W]
out_a  output  NUM_CH  H-bridge forward leg, registered
out_b  output  NUM_CH  H-bridge reverse leg, registered
busy  output  NUM_CH  1 while the channel is in DEAD
led  output  3  channel-0 status

Behaviour:
- Reset: one clock with rst_n=0 sets all channels to STOP, dead counters to 0, duty_q to 0, and pwm_cnt to 0. Outputs out_a=0, out_b=0, busy=0, led=3'b011. A reset mid-operation, including mid-DEAD, takes effect at the next edge.
- Request decode per channel:
  - req=FWD when en & cmd_fwd & ~cmd_rev.
  - req=REV when en & cmd_rev & ~cmd_fwd.
  - Otherwise req=STOP; a conflict (both asserted) counts as STOP.
- pwm_cnt: a single free-running PWM_W-bit counter shared by all channels; wraps from 2^PWM_W-1 to 0.
- duty_q[i]: loaded from duty[i] only on the cycle pwm_cnt==2^PWM_W-1. A new duty therefore takes effect at the next period start, with no mid-period glitch.
- FSM transitions (state register updates on the edge where req is sampled):
  - STOP: req=FWD -> FWD; req=REV -> REV; else stay.
  - FWD: req=FWD -> stay; else -> DEAD with dead_cnt loaded to DEAD_CYC-1.
  - REV: req=REV -> stay; else -> DEAD with dead_cnt loaded to DEAD_CYC-1.
  - DEAD: while dead_cnt!=0, decrement and stay. The request is ignored, including a return to the original direction.
  - DEAD exit (dead_cnt==0): go to req sampled that cycle (STOP, FWD or REV). Thus every FWD<->REV reversal passes through exactly DEAD_CYC cycles of both legs low.
- Output registers, updated each edge from the current state:
  - out_a = (state==FWD) & (pwm_cnt < duty_q).
  - out_b = (state==REV) & (pwm_cnt < duty_q).
  - duty_q=0 gives always low; all-ones gives high for 2^PWM_W-1 of every 2^PWM_W cycles.
  - out_a & out_b is never 1 in the same cycle in FWD/REV/DEAD.
- Latency: a request present before edge N changes state at edge N; out_a/out_b reflect it after edge N+1.
- busy[i] is registered and equals (state==DEAD).
- led is registered, from channel 0:
  - 3'b101 when req0=FWD.
  - 3'b110 when req0=REV.
  - 3'b000 on conflict (en & cmd_fwd[0] & cmd_rev[0]).
  - 3'b011 otherwise.
- Channels are fully independent apart from the shared pwm_cnt and en.

Optional Feature:
Macro DC_MOTOR_BRAKE_EN.
- Defined: in STOP state out_a=out_b=1 (active low-side brake). DEAD still drives both 0, so FWD/REV -> STOP shows DEAD_CYC cycles low before the brake applies.
- Undefined: STOP drives both 0 (coast). The reset value is both 0 in either build.

Test Plan:
All scenarios use NUM_CH=2, PWM_W=4, DEAD_CYC=4.
1. rst_n=0 for 3 cycles with random cmd/duty -> out_a=out_b=0, busy=0, led=3'b011; after release with no cmd, outputs stay 0.
2. ch0 cmd_fwd=1, duty0=8 -> after the first wrap, out_a[0] high for pwm_cnt 0..7 and low for 8..15 every 16 cycles; out_b[0]=0; led=3'b101; ch1 unaffected.
3. ch0 FWD running, switch to cmd_rev=1 -> busy[0]=1 and out_a=out_b=0 for exactly 4 cycles, then out_b[0] PWMs at duty0; out_a[0] never overlaps out_b[0].
4. ch1 in REV, assert cmd_fwd[1] and cmd_rev[1] together -> 4-cycle DEAD then STOP. Separately, both asserted on ch0 -> led=3'b000.
5. duty0 changed 8->3 when pwm_cnt=5 -> current period keeps 8 high cycles; next period has 3. Also duty0=0 -> out_a never high; duty0=15 -> high 15 of 16.
6. Assert rst_n=0 when DEAD dead_cnt=2 -> next edge STOP, busy=0. With DC_MOTOR_BRAKE_EN: FWD -> STOP shows 4 cycles both-0, then out_a=out_b=1.
